// File: rtl/alu_seq_pkg.sv
// Shared state encoding and default widths for the ALU sequencing controller.
package alu_seq_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int ADDR_WIDTH_DEF = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_LATCH,
    ST_EXEC,
    ST_WR,
    ST_DONE
  } state_e;

endpackage

// File: rtl/alu_seq_addr_gen.sv
// Element index counter with wrapping src/dst address adders.
// Addresses are computed from the next index so the controller can register them.
module alu_seq_addr_gen #(
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clr,
  input  logic                  inc,
  input  logic [ADDR_WIDTH-1:0] src_base,
  input  logic [ADDR_WIDTH-1:0] dst_base,
  output logic [ADDR_WIDTH:0]   idx,
  output logic [ADDR_WIDTH-1:0] src_addr,
  output logic [ADDR_WIDTH-1:0] dst_addr
);

  localparam logic [ADDR_WIDTH:0] IDX_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

  logic [ADDR_WIDTH:0] idx_q, idx_d;

  always_comb begin
    idx_d = idx_q;
    if (clr)
      idx_d = '0;
    else if (inc)
      idx_d = idx_q + IDX_ONE;
  end

  always_ff @(posedge clk) begin
    if (reset)
      idx_q <= '0;
    else
      idx_q <= idx_d;
  end

  // Truncation to ADDR_WIDTH bits gives the modulo-2^ADDR_WIDTH wrap.
  assign src_addr = src_base + idx_d[ADDR_WIDTH-1:0];
  assign dst_addr = dst_base + idx_d[ADDR_WIDTH-1:0];
  assign idx      = idx_q;

endmodule

// File: rtl/alu_seq_ctrl.sv
// Sequences RAM0/RAM1 reads through an external ALU and writes results to RAM0.
// Optional carry counter enabled by ALU_SEQ_CARRY_CNT_EN.
//   state | meaning
//   IDLE  | wait for start
//   RD    | read RAM0/RAM1 at src+i
//   LATCH | capture read data into ALU operands
//   EXEC  | ALU evaluates, operands held
//   WR    | write result to RAM0 at dst+i
//   DONE  | one-cycle done pulse
module alu_seq_ctrl
  import alu_seq_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] opcode_cfg,
  input  logic [ADDR_WIDTH-1:0] src_addr,
  input  logic [ADDR_WIDTH-1:0] dst_addr,
  input  logic [ADDR_WIDTH:0]   len,
  input  logic [DATA_WIDTH-1:0] rd_data_0,
  input  logic [DATA_WIDTH-1:0] rd_data_1,
  input  logic [DATA_WIDTH-1:0] result_in,
  input  logic                  carry_in,
  output logic                  CS_0,
  output logic                  CS_1,
  output logic                  wr_en_0,
  output logic                  wr_en_1,
  output logic [ADDR_WIDTH-1:0] addr_in_0,
  output logic [ADDR_WIDTH-1:0] addr_in_1,
  output logic [DATA_WIDTH-1:0] wr_data_0,
  output logic [DATA_WIDTH-1:0] a_in,
  output logic [DATA_WIDTH-1:0] b_in,
  output logic [ADDR_WIDTH-1:0] opcode_in,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH:0]   carry_cnt
);

  localparam logic [ADDR_WIDTH:0] IDX_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

  state_e state_q, state_d;
  logic   accept, last;

  logic [ADDR_WIDTH-1:0] op_q, op_d, src_q, src_d, dst_q, dst_d;
  logic [ADDR_WIDTH:0]   len_q, len_d, idx;
  logic [ADDR_WIDTH-1:0] gen_src, gen_dst;

  logic                  cs_0_q, cs_0_d, cs_1_q, cs_1_d, wr_en_0_q, wr_en_0_d;
  logic                  busy_q, busy_d, done_q, done_d;
  logic [ADDR_WIDTH-1:0] addr_0_q, addr_0_d, addr_1_q, addr_1_d, opc_q, opc_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d, a_q, a_d, b_q, b_d;

  assign accept = (state_q == ST_IDLE) && start;
  assign last   = (idx + IDX_ONE) >= len_q;

  always_comb begin
    op_d  = accept ? opcode_cfg : op_q;
    src_d = accept ? src_addr   : src_q;
    dst_d = accept ? dst_addr   : dst_q;
    len_d = accept ? len        : len_q;
  end

  alu_seq_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_addr_gen (
    .clk      (clk),
    .reset    (reset),
    .clr      (accept),
    .inc      (state_q == ST_WR),
    .src_base (src_d),
    .dst_base (dst_d),
    .idx      (idx),
    .src_addr (gen_src),
    .dst_addr (gen_dst)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = (len == '0) ? ST_DONE : ST_RD;
      ST_RD:    state_d = ST_LATCH;
      ST_LATCH: state_d = ST_EXEC;
      ST_EXEC:  state_d = ST_WR;
      ST_WR:    state_d = last ? ST_DONE : ST_RD;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Outputs are registered, so they are decoded from the state being entered.
  always_comb begin
    cs_0_d    = (state_d == ST_RD) || (state_d == ST_WR);
    cs_1_d    = (state_d == ST_RD);
    wr_en_0_d = (state_d == ST_WR);
    busy_d    = (state_d == ST_RD) || (state_d == ST_LATCH) ||
                (state_d == ST_EXEC) || (state_d == ST_WR);
    done_d    = (state_d == ST_DONE);
    addr_0_d  = addr_0_q;
    addr_1_d  = addr_1_q;
    wdata_d   = wdata_q;
    a_d       = a_q;
    b_d       = b_q;
    opc_d     = opc_q;
    if (state_d == ST_RD) begin
      addr_0_d = gen_src;
      addr_1_d = gen_src;
    end
    if (state_d == ST_WR) begin
      addr_0_d = gen_dst;
      wdata_d  = result_in;
    end
    if (state_q == ST_LATCH) begin
      a_d   = rd_data_0;
      b_d   = rd_data_1;
      opc_d = op_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      op_q      <= '0;
      src_q     <= '0;
      dst_q     <= '0;
      len_q     <= '0;
      cs_0_q    <= 1'b0;
      cs_1_q    <= 1'b0;
      wr_en_0_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      addr_0_q  <= '0;
      addr_1_q  <= '0;
      wdata_q   <= '0;
      a_q       <= '0;
      b_q       <= '0;
      opc_q     <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      len_q     <= len_d;
      cs_0_q    <= cs_0_d;
      cs_1_q    <= cs_1_d;
      wr_en_0_q <= wr_en_0_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      addr_0_q  <= addr_0_d;
      addr_1_q  <= addr_1_d;
      wdata_q   <= wdata_d;
      a_q       <= a_d;
      b_q       <= b_d;
      opc_q     <= opc_d;
    end
  end

`ifdef ALU_SEQ_CARRY_CNT_EN
  logic [ADDR_WIDTH:0] carry_cnt_q, carry_cnt_d;

  always_comb begin
    carry_cnt_d = carry_cnt_q;
    if (accept)
      carry_cnt_d = '0;
    else if ((state_q == ST_WR) && carry_in)
      carry_cnt_d = carry_cnt_q + IDX_ONE;
  end

  always_ff @(posedge clk) begin
    if (reset)
      carry_cnt_q <= '0;
    else
      carry_cnt_q <= carry_cnt_d;
  end

  assign carry_cnt = carry_cnt_q;
`else
  logic unused_carry_in;
  assign unused_carry_in = carry_in;
  assign carry_cnt       = '0;
`endif

  assign CS_0      = cs_0_q;
  assign CS_1      = cs_1_q;
  assign wr_en_0   = wr_en_0_q;
  assign wr_en_1   = 1'b0;
  assign addr_in_0 = addr_0_q;
  assign addr_in_1 = addr_1_q;
  assign wr_data_0 = wdata_q;
  assign a_in      = a_q;
  assign b_in      = b_q;
  assign opcode_in = opc_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl with behavioural RAM0/RAM1 and ALU models.
module tb_alu_seq_ctrl;

  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_XOR = 4'h6;

  logic       clk = 1'b0;
  logic       reset, start, carry_in;
  logic [3:0] opcode_cfg, src_addr, dst_addr, addr_in_0, addr_in_1, opcode_in;
  logic [4:0] len, carry_cnt;
  logic [7:0] rd_data_0, rd_data_1, result_in, wr_data_0, a_in, b_in;
  logic       CS_0, CS_1, wr_en_0, wr_en_1, busy, done;

  logic [7:0] mem0 [16];
  logic [7:0] mem1 [16];
  logic [3:0] rd_q[$];
  logic [3:0] wr_q[$];
  int busy_cnt = 0, done_cnt = 0, cs_cnt = 0, cs1_bad = 0;
  int n_checks = 0, n_fail = 0;

  always #5 clk = ~clk;

  alu_seq_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .opcode_cfg(opcode_cfg),
    .src_addr(src_addr), .dst_addr(dst_addr), .len(len),
    .rd_data_0(rd_data_0), .rd_data_1(rd_data_1), .result_in(result_in),
    .carry_in(carry_in), .CS_0(CS_0), .CS_1(CS_1), .wr_en_0(wr_en_0),
    .wr_en_1(wr_en_1), .addr_in_0(addr_in_0), .addr_in_1(addr_in_1),
    .wr_data_0(wr_data_0), .a_in(a_in), .b_in(b_in), .opcode_in(opcode_in),
    .busy(busy), .done(done), .carry_cnt(carry_cnt)
  );

  always_comb begin
    result_in = 8'h00;
    carry_in  = 1'b0;
    case (opcode_in)
      OP_ADD:  {carry_in, result_in} = {1'b0, a_in} + {1'b0, b_in};
      OP_XOR:  result_in = a_in ^ b_in;
      default: result_in = 8'h00;
    endcase
  end

  always @(posedge clk) begin
    if (CS_0) begin
      if (wr_en_0) mem0[addr_in_0] <= wr_data_0;
      else         rd_data_0 <= mem0[addr_in_0];
    end
    if (CS_1 && !wr_en_1) rd_data_1 <= mem1[addr_in_1];
  end

  always @(negedge clk) begin
    if (busy) busy_cnt++;
    if (done) done_cnt++;
    if (CS_0 || CS_1) cs_cnt++;
    if (CS_0 && wr_en_0) wr_q.push_back(addr_in_0);
    if (CS_0 && !wr_en_0) rd_q.push_back(addr_in_0);
    if (wr_en_1 || (CS_1 && !(CS_0 && !wr_en_0)) || (CS_1 && addr_in_1 !== addr_in_0))
      cs1_bad++;
  end

  task automatic go(input logic [3:0] op, input logic [3:0] src, input logic [3:0] dst,
                    input logic [4:0] n);
    @(negedge clk);
    opcode_cfg = op; src_addr = src; dst_addr = dst; len = n; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    opcode_cfg = ~op; src_addr = ~src; dst_addr = ~dst; len = 5'd1;
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; opcode_cfg = '0; src_addr = '0; dst_addr = '0; len = '0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({CS_0, CS_1, wr_en_0, wr_en_1, busy, done, addr_in_0, addr_in_1, wr_data_0,
         a_in, b_in, opcode_in, carry_cnt} !== '0) begin
      n_fail++; $display("FAIL reset_outputs: busy=%b done=%b CS_0=%b a_in=%h, required all 0",
                         busy, done, CS_0, a_in);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic;
    int b0, d0, r0, w0;
    for (int k = 0; k < 16; k++) begin mem0[k] = 8'h00; mem1[k] = 8'd10; end
    for (int k = 0; k < 4; k++) mem0[k+2] = 8'(k + 1);
    b0 = busy_cnt; d0 = done_cnt; r0 = rd_q.size(); w0 = wr_q.size();
    go(OP_ADD, 4'd2, 4'd8, 5'd4);
    repeat (22) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (mem0[k+8] !== 8'(11 + k)) begin
        n_fail++; $display("FAIL basic_result[%0d]: got %0d, required %0d", k, mem0[k+8], 11 + k);
      end
    end
    n_checks++;
    if (busy_cnt - b0 != 16) begin
      n_fail++; $display("FAIL basic_busy_cycles: got %0d, required 16", busy_cnt - b0);
    end
    n_checks++;
    if (done_cnt - d0 != 1) begin
      n_fail++; $display("FAIL basic_done_pulses: got %0d, required 1", done_cnt - d0);
    end
    n_checks++;
    if (rd_q.size() - r0 != 4 || wr_q.size() - w0 != 4) begin
      n_fail++; $display("FAIL basic_access_count: reads %0d writes %0d, required 4 and 4",
                         rd_q.size() - r0, wr_q.size() - w0);
    end else begin
      for (int k = 0; k < 4; k++) begin
        n_checks++;
        if (rd_q[r0+k] !== 4'(2 + k) || wr_q[w0+k] !== 4'(8 + k)) begin
          n_fail++; $display("FAIL basic_addr[%0d]: rd %0d wr %0d, required %0d and %0d",
                             k, rd_q[r0+k], wr_q[w0+k], 2 + k, 8 + k);
        end
      end
    end
    n_checks++;
    if (opcode_in !== OP_ADD || a_in !== 8'd4 || b_in !== 8'd10 || wr_data_0 !== 8'd14) begin
      n_fail++; $display("FAIL basic_held_regs: op %h a %0d b %0d wd %0d, required 1 4 10 14",
                         opcode_in, a_in, b_in, wr_data_0);
    end
  endtask

  task automatic test_len0;
    int c0, r0, w0, d0;
    c0 = cs_cnt; r0 = rd_q.size(); w0 = wr_q.size(); d0 = done_cnt;
    go(OP_ADD, 4'd3, 4'd5, 5'd0);
    n_checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL len0_done: done=%b busy=%b, required 1 and 0", done, busy);
    end
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0) begin
      n_fail++; $display("FAIL len0_pulse_width: done=%b, required 0", done);
    end
    repeat (4) @(negedge clk);
    n_checks++;
    if (cs_cnt != c0 || rd_q.size() != r0 || wr_q.size() != w0 || done_cnt - d0 != 1) begin
      n_fail++; $display("FAIL len0_no_access: cs cycles %0d dones %0d, required 0 and 1",
                         cs_cnt - c0, done_cnt - d0);
    end
  endtask

  task automatic test_wrap;
    logic [3:0] exp_rd [3];
    logic [3:0] exp_wr [3];
    int r0, w0;
    exp_rd[0] = 4'd15; exp_rd[1] = 4'd0; exp_rd[2] = 4'd1;
    exp_wr[0] = 4'd14; exp_wr[1] = 4'd15; exp_wr[2] = 4'd0;
    for (int k = 0; k < 16; k++) begin mem0[k] = 8'h00; mem1[k] = 8'd10; end
    mem0[15] = 8'd5; mem0[0] = 8'd6; mem0[1] = 8'd7;
    r0 = rd_q.size(); w0 = wr_q.size();
    go(OP_ADD, 4'd15, 4'd14, 5'd3);
    repeat (18) @(negedge clk);
    n_checks++;
    if (rd_q.size() - r0 != 3 || wr_q.size() - w0 != 3) begin
      n_fail++; $display("FAIL wrap_access_count: reads %0d writes %0d, required 3 and 3",
                         rd_q.size() - r0, wr_q.size() - w0);
    end else begin
      for (int k = 0; k < 3; k++) begin
        n_checks++;
        if (rd_q[r0+k] !== exp_rd[k] || wr_q[w0+k] !== exp_wr[k]) begin
          n_fail++; $display("FAIL wrap_addr[%0d]: rd %0d wr %0d, required %0d and %0d",
                             k, rd_q[r0+k], wr_q[w0+k], exp_rd[k], exp_wr[k]);
        end
      end
    end
    n_checks++;
    if (mem0[14] !== 8'd15 || mem0[15] !== 8'd16 || mem0[0] !== 8'd17) begin
      n_fail++; $display("FAIL wrap_data: got %0d %0d %0d, required 15 16 17",
                         mem0[14], mem0[15], mem0[0]);
    end
  endtask

  task automatic test_back_to_back_start;
    int b0, d0, w0;
    for (int k = 0; k < 16; k++) begin mem0[k] = 8'h55; mem1[k] = 8'd10; end
    mem0[0] = 8'd3; mem0[1] = 8'd4;
    b0 = busy_cnt; d0 = done_cnt; w0 = wr_q.size();
    go(OP_ADD, 4'd0, 4'd4, 5'd2);
    repeat (4) @(negedge clk);
    opcode_cfg = OP_XOR; src_addr = 4'd8; dst_addr = 4'd12; len = 5'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    n_checks++;
    if (busy_cnt - b0 != 8 || done_cnt - d0 != 1) begin
      n_fail++; $display("FAIL ignore_start_counts: busy %0d done %0d, required 8 and 1",
                         busy_cnt - b0, done_cnt - d0);
    end
    n_checks++;
    if (wr_q.size() - w0 != 2 || mem0[4] !== 8'd13 || mem0[5] !== 8'd14 || mem0[12] !== 8'h55) begin
      n_fail++; $display("FAIL ignore_start_writes: writes %0d m4 %0d m5 %0d m12 %h, required 2 13 14 55",
                         wr_q.size() - w0, mem0[4], mem0[5], mem0[12]);
    end
  endtask

  task automatic test_reset_mid;
    int b0, d0, w0;
    for (int k = 0; k < 16; k++) begin mem0[k] = 8'hAA; mem1[k] = 8'd1; end
    b0 = busy_cnt; d0 = done_cnt; w0 = wr_q.size();
    go(OP_ADD, 4'd0, 4'd8, 5'd3);
    repeat (6) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({CS_0, CS_1, wr_en_0, wr_en_1, busy, done, addr_in_0, addr_in_1, wr_data_0,
         a_in, b_in, opcode_in, carry_cnt} !== '0) begin
      n_fail++; $display("FAIL reset_mid_outputs: busy=%b CS_0=%b a_in=%h wd=%h, required all 0",
                         busy, CS_0, a_in, wr_data_0);
    end
    reset = 1'b0;
    repeat (20) @(negedge clk);
    n_checks++;
    if (busy_cnt - b0 != 7 || done_cnt - d0 != 0 || wr_q.size() - w0 != 1) begin
      n_fail++; $display("FAIL reset_mid_abort: busy %0d done %0d writes %0d, required 7 0 1",
                         busy_cnt - b0, done_cnt - d0, wr_q.size() - w0);
    end
    n_checks++;
    if (mem0[8] !== 8'hAB || mem0[9] !== 8'hAA) begin
      n_fail++; $display("FAIL reset_mid_mem: m8 %h m9 %h, required ab aa", mem0[8], mem0[9]);
    end
  endtask

  task automatic test_full_len;
    int b0, d0, bad;
    for (int k = 0; k < 16; k++) begin mem0[k] = 8'(k * 3 + 1); mem1[k] = 8'hFF; end
    b0 = busy_cnt; d0 = done_cnt; bad = 0;
    go(OP_XOR, 4'd0, 4'd0, 5'd16);
    repeat (70) @(negedge clk);
    for (int k = 0; k < 16; k++)
      if (mem0[k] !== (8'(k * 3 + 1) ^ 8'hFF)) bad++;
    n_checks++;
    if (bad != 0) begin
      n_fail++; $display("FAIL full_len_data: %0d wrong locations, required 0", bad);
    end
    n_checks++;
    if (busy_cnt - b0 != 64 || done_cnt - d0 != 1) begin
      n_fail++; $display("FAIL full_len_counts: busy %0d done %0d, required 64 and 1",
                         busy_cnt - b0, done_cnt - d0);
    end
  endtask

  task automatic test_carry_cnt;
    logic [4:0] exp_cnt;
`ifdef ALU_SEQ_CARRY_CNT_EN
    exp_cnt = 5'd3;
`else
    exp_cnt = 5'd0;
`endif
    for (int k = 0; k < 16; k++) begin mem0[k] = 8'hF0; mem1[k] = 8'h20; end
    go(OP_ADD, 4'd0, 4'd4, 5'd3);
    repeat (20) @(negedge clk);
    n_checks++;
    if (carry_cnt !== exp_cnt) begin
      n_fail++; $display("FAIL carry_cnt: got %0d, required %0d", carry_cnt, exp_cnt);
    end
    n_checks++;
    if (mem0[4] !== 8'h10 || mem0[6] !== 8'h10) begin
      n_fail++; $display("FAIL carry_data: m4 %h m6 %h, required 10 10", mem0[4], mem0[6]);
    end
    n_checks++;
    if (cs1_bad != 0) begin
      n_fail++; $display("FAIL ram1_port_misuse: %0d bad cycles, required 0", cs1_bad);
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_len0;
    test_wrap;
    test_back_to_back_start;
    test_reset_mid;
    test_full_len;
    test_carry_cnt;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_seq_ctrl.md
ALU_SEQ_CTRL -- requirements
Module: alu_seq_ctrl

Interface
REQ-001 DATA_WIDTH, 8, operand/result width.
REQ-002 ADDR_WIDTH, 4, RAM address width and opcode width.
REQ-003 clk  in  1  single clock; all logic on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 start  in  1  job request; accepted only in IDLE.
REQ-006 opcode_cfg  in  ADDR_WIDTH  ALU opcode for the job.
REQ-007 src_addr  in  ADDR_WIDTH  first operand address (same for RAM0 and RAM1).
REQ-008 dst_addr  in  ADDR_WIDTH  first result address in RAM0.
REQ-009 len  in  ADDR_WIDTH+1  element count, 0..2^ADDR_WIDTH.
REQ-010 rd_data_0, rd_data_1  in  DATA_WIDTH  RAM0/RAM1 read data, valid 1 cycle after a read.
REQ-011 result_in  in  DATA_WIDTH  ALU result, valid 1 cycle after operands/opcode applied.
REQ-012 carry_in  in  1  ALU carry, aligned with result_in.
REQ-013 CS_0, CS_1, wr_en_0, wr_en_1  out  1 each  RAM chip selects and write enables.
REQ-014 addr_in_0, addr_in_1  out  ADDR_WIDTH  RAM addresses.
REQ-015 wr_data_0  out  DATA_WIDTH  RAM0 write data.
REQ-016 a_in, b_in  out  DATA_WIDTH; opcode_in  out  ADDR_WIDTH  ALU operands/opcode.
REQ-017 busy  out  1; done  out  1 (one-cycle pulse); carry_cnt  out  ADDR_WIDTH+1.

Function
REQ-018 FSM states IDLE, RD, LATCH, EXEC, WR, DONE; all outputs registered.
REQ-019 IDLE: start=1 and len!=0 -> RD; start=1 and len=0 -> DONE with no RAM access; otherwise stay.
REQ-020 opcode_cfg, src_addr, dst_addr, len sampled only on start acceptance; later changes ignored.
REQ-021 RD: CS_0=CS_1=1, wr_en_0=wr_en_1=0, addr_in_0=addr_in_1=src_addr+i; -> LATCH.
REQ-022 LATCH: CS deasserted; rd_data_0/rd_data_1 registered into a_in/b_in, opcode_in=opcode; -> EXEC.
REQ-023 EXEC: a_in/b_in/opcode_in held stable; -> WR.
REQ-024 WR: CS_0=1, wr_en_0=1, addr_in_0=dst_addr+i, wr_data_0=result_in; i increments; -> RD if i+1<len else DONE.
REQ-025 Each element takes exactly 4 cycles; job of len N keeps busy high 4N cycles.
REQ-026 DONE: done=1 for one cycle, busy=0; -> IDLE; start in DONE ignored.
REQ-027 busy=1 in RD, LATCH, EXEC, WR; start while busy ignored, no job queued.
REQ-028 Addresses wrap modulo 2^ADDR_WIDTH (src_addr=15, i=1 -> address 0).
REQ-029 len=2^ADDR_WIDTH processes all 16 locations; overlapping src/dst regions permitted, processed in ascending i order.
REQ-030 CS_1 and wr_en_1 never asserted outside RD; wr_en_1 always 0.

Reset
REQ-031 reset=1 forces IDLE at next edge, from any state, including mid-job.
REQ-032 Reset values: busy=0, done=0, all CS/wr_en=0, all addresses/data/a_in/b_in/opcode_in=0, carry_cnt=0.
REQ-033 Aborted job is not resumed; no done pulse for it.

Configuration
REQ-034 Macro ALU_SEQ_CARRY_CNT_EN: when defined, carry_cnt clears on start acceptance and increments in each WR cycle with carry_in=1; holds after DONE until next start.
REQ-035 Without ALU_SEQ_CARRY_CNT_EN, carry_cnt is constant 0 and no counter logic is generated.

Structure
REQ-036 Package alu_seq_pkg holds the state enumeration and default width constants.
REQ-037 One sub-module alu_seq_addr_gen: element index counter plus src/dst address adders with wrap.

Verification
REQ-038 len=4, src=2, dst=8, opcode=ADD, RAM0[2..5]=1,2,3,4, RAM1=10 -> RAM0[8..11]=11,12,13,14, busy 16 cycles, one done pulse.
REQ-039 len=0, start=1 -> done pulse 1 cycle later, no CS asserted.
REQ-040 len=3, src=15, dst=14 -> reads at 15,0,1; writes at 14,15,0.
REQ-041 start pulsed again 5 cycles into a len=2 job -> ignored; exactly 8 busy cycles, one done.
REQ-042 reset asserted in EXEC of element 1 -> next cycle IDLE, all outputs 0, no further writes, no done.
REQ-043 ALU_SEQ_CARRY_CNT_EN defined, ADD of 0xF0+0x20 on 3 elements -> carry_cnt=3; undefined -> carry_cnt=0.
